// File: rtl/time_setter.sv
// Button-driven time-entry controller for the Clock block: debounces mode/inc buttons,
// walks hour -> minute -> second editing and strobes the edited time into Clock on commit.
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic [5:0] sec_in,
    output logic [5:0] min_in,
    output logic [4:0] hour_in,
    output logic       set,
    output logic       editing,
    output logic [1:0] field
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HOUR, MIN, SEC, COMMIT} state_t;

    // Bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_prev;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic          mode_press;
    logic          inc_press;

    state_t        state;
    state_t        state_next;
    logic [4:0]    hour_q;
    logic [4:0]    hour_d;
    logic [5:0]    min_q;
    logic [5:0]    min_d;
    logic [5:0]    sec_q;
    logic [5:0]    sec_d;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_next;

    assign raw        = {btn_inc, btn_mode};
    assign mode_press = press[0];
    assign inc_press  = press[1];

    // The debounced level only follows the synchronized input after a run of
    // DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            to_cnt <= to_next;
        end
    end

    // Mode takes priority over increment when both press pulses coincide.
    always_comb begin
        state_next = state;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        to_next    = to_cnt;
        case (state)
            IDLE: begin
                if (mode_press) begin
                    hour_d     = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                    min_d      = (cur_min > 6'd59) ? 6'd0 : cur_min;
                    sec_d      = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
                    to_next    = '0;
                    state_next = HOUR;
                end
            end
            HOUR, MIN, SEC: begin
                if (mode_press) begin
                    to_next = '0;
                    if (state == HOUR) begin
                        state_next = MIN;
                    end else if (state == MIN) begin
                        state_next = SEC;
                    end else begin
                        state_next = COMMIT;
                    end
                end else if (inc_press) begin
                    to_next = '0;
                    if (state == HOUR) begin
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else if (state == MIN) begin
                        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    end else begin
                        sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    end
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_next    = '0;
                    state_next = IDLE;
                end else begin
                    to_next = to_cnt + TW'(1);
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hour_in = hour_q;
    assign min_in  = min_q;
    assign sec_in  = sec_q;
    assign set     = (state == COMMIT);
    assign editing = (state == HOUR) || (state == MIN) || (state == SEC);

    always_comb begin
        field = 2'd0;
        case (state)
            HOUR:    field = 2'd1;
            MIN:     field = 2'd2;
            SEC:     field = 2'd3;
            default: field = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_time_setter.sv
// Directed self-checking bench for time_setter: one instance with a long timeout for the
// editing flow and a second one with a 20-cycle timeout for abort/latency checks.
module tb_time_setter;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] cur_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hour;

    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [4:0] hour_in;
    logic       set;
    logic       editing;
    logic [1:0] field;

    logic [5:0] sec_in_to;
    logic [5:0] min_in_to;
    logic [4:0] hour_in_to;
    logic       set_to;
    logic       editing_to;
    logic [1:0] field_to;

    int checks       = 0;
    int failures     = 0;
    int set_count    = 0;
    int set_count_to = 0;
    int set_before;
    logic [4:0] cap_hour = '0;
    logic [5:0] cap_min  = '0;
    logic [5:0] cap_sec  = '0;

    time_setter #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .set(set), .editing(editing), .field(field)
    );

    time_setter #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_to (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .sec_in(sec_in_to), .min_in(min_in_to), .hour_in(hour_in_to),
        .set(set_to), .editing(editing_to), .field(field_to)
    );

    always #5 clk = ~clk;

    // Count set cycles and capture the bus value presented while set is high.
    always @(negedge clk) begin
        if (set === 1'b1) begin
            set_count = set_count + 1;
            cap_hour  = hour_in;
            cap_min   = min_in;
            cap_sec   = sec_in;
        end
        if (set_to === 1'b1) begin
            set_count_to = set_count_to + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    task automatic pressButton(input logic mode, input logic inc);
        @(negedge clk);
        btn_mode = mode;
        btn_inc  = inc;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_hour", 32'(hour_in), 0);
        checkOutput("reset_min", 32'(min_in), 0);
        checkOutput("reset_sec", 32'(sec_in), 0);
        checkOutput("reset_set", 32'(set), 0);
        checkOutput("reset_editing", 32'(editing), 0);
        checkOutput("reset_field", 32'(field), 0);

        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("idle_no_set", 32'(set_count), 0);
        checkOutput("idle_editing", 32'(editing), 0);
        checkOutput("idle_hour", 32'(hour_in), 0);

        $display("[TB] commit without changes");
        applyStimulus(1, 58, 30);
        pressButton(1'b1, 1'b0);
        checkOutput("c1_field_hour", 32'(field), 1);
        checkOutput("c1_editing", 32'(editing), 1);
        checkOutput("c1_pre_hour", 32'(hour_in), 1);
        checkOutput("c1_pre_min", 32'(min_in), 58);
        checkOutput("c1_pre_sec", 32'(sec_in), 30);
        pressButton(1'b1, 1'b0);
        checkOutput("c1_field_min", 32'(field), 2);
        pressButton(1'b1, 1'b0);
        checkOutput("c1_field_sec", 32'(field), 3);
        checkOutput("c1_no_set_yet", 32'(set_count), 0);
        pressButton(1'b1, 1'b0);
        checkOutput("c1_set_count", 32'(set_count), 1);
        checkOutput("c1_set_hour", 32'(cap_hour), 1);
        checkOutput("c1_set_min", 32'(cap_min), 58);
        checkOutput("c1_set_sec", 32'(cap_sec), 30);
        checkOutput("c1_editing_off", 32'(editing), 0);
        checkOutput("c1_field_off", 32'(field), 0);
        checkOutput("c1_hold_hour", 32'(hour_in), 1);

        $display("[TB] preload clamp and wrap");
        applyStimulus(23, 59, 62);
        pressButton(1'b1, 1'b0);
        checkOutput("c2_pre_hour", 32'(hour_in), 23);
        checkOutput("c2_pre_min", 32'(min_in), 59);
        checkOutput("c2_pre_sec_clamp", 32'(sec_in), 0);
        pressButton(1'b0, 1'b1);
        checkOutput("c2_hour_wrap", 32'(hour_in), 0);
        pressButton(1'b1, 1'b0);
        pressButton(1'b0, 1'b1);
        checkOutput("c2_min_wrap", 32'(min_in), 0);
        pressButton(1'b1, 1'b0);
        pressButton(1'b0, 1'b1);
        checkOutput("c2_sec_inc", 32'(sec_in), 1);
        pressButton(1'b1, 1'b0);
        checkOutput("c2_set_count", 32'(set_count), 2);
        checkOutput("c2_set_hour", 32'(cap_hour), 0);
        checkOutput("c2_set_min", 32'(cap_min), 0);
        checkOutput("c2_set_sec", 32'(cap_sec), 1);

        $display("[TB] simultaneous mode and inc");
        applyStimulus(12, 0, 0);
        pressButton(1'b1, 1'b0);
        checkOutput("sim_hour_pre", 32'(hour_in), 12);
        pressButton(1'b1, 1'b1);
        checkOutput("sim_field", 32'(field), 2);
        checkOutput("sim_hour_kept", 32'(hour_in), 12);
        pulseReset();
        checkOutput("sim_reset_field", 32'(field), 0);

        $display("[TB] bounce rejection");
        applyStimulus(5, 10, 20);
        pressButton(1'b1, 1'b0);
        checkOutput("b_hour_pre", 32'(hour_in), 5);
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        checkOutput("b_no_press", 32'(hour_in), 5);
        btn_inc = 1'b1;
        repeat (12) @(negedge clk);
        btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("b_one_press", 32'(hour_in), 6);
        checkOutput("b_field", 32'(field), 1);

        $display("[TB] mid-edit reset");
        pressButton(1'b1, 1'b0);
        pressButton(1'b1, 1'b0);
        checkOutput("r_field_sec", 32'(field), 3);
        set_before = set_count;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("r_field", 32'(field), 0);
        checkOutput("r_editing", 32'(editing), 0);
        checkOutput("r_set", 32'(set), 0);
        checkOutput("r_hour", 32'(hour_in), 0);
        checkOutput("r_sec", 32'(sec_in), 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(7, 8, 9);
        pressButton(1'b1, 1'b0);
        checkOutput("r_reenter_field", 32'(field), 1);
        checkOutput("r_reload_hour", 32'(hour_in), 7);
        checkOutput("r_reload_min", 32'(min_in), 8);
        checkOutput("r_reload_sec", 32'(sec_in), 9);
        checkOutput("r_no_set", 32'(set_count), set_before);

        $display("[TB] press latency and timeout");
        pulseReset();
        applyStimulus(1, 2, 3);
        set_before = set_count_to;
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (7) @(negedge clk);
        checkOutput("lat_before", 32'(field_to), 0);
        @(negedge clk);
        checkOutput("lat_at", 32'(field_to), 1);
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        pressButton(1'b1, 1'b0);
        checkOutput("to_in_min", 32'(field_to), 2);
        repeat (11) @(negedge clk);
        checkOutput("to_cycle19", 32'(editing_to), 1);
        @(negedge clk);
        checkOutput("to_cycle20", 32'(editing_to), 0);
        checkOutput("to_field", 32'(field_to), 0);
        repeat (5) @(negedge clk);
        checkOutput("to_no_set", 32'(set_count_to), set_before);
        checkOutput("to_shadow_kept", 32'(hour_in_to), 1);
        checkOutput("long_to_still_min", 32'(field), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
